// File: rtl/store.sv
// rtl/store.sv - Wishbone store unit: one big-endian write cycle per aligned request
module store #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic [3:0]  o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [1:0]  i_store,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_BUS
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          misaligned;
    logic [3:0]    lane_sel;
    logic [31:0]   lane_dat;
    logic          timed_out;

    // Read data is never consumed by a store.
    logic unused_rd;
    assign unused_rd = ^i_wb_dat;

    // Lane 3 carries the lowest byte address (big-endian bus).
    always_comb begin
        lane_sel   = 4'b0000;
        lane_dat   = i_data;
        misaligned = 1'b0;
        case (i_store)
            2'd1: begin
                lane_sel = 4'b1000 >> i_addr[1:0];
                lane_dat = {4{i_data[7:0]}};
            end
            2'd2: begin
                lane_sel   = i_addr[1] ? 4'b0011 : 4'b1100;
                lane_dat   = {2{i_data[15:0]}};
                misaligned = i_addr[0];
            end
            2'd3: begin
                lane_sel   = 4'b1111;
                misaligned = (i_addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    assign timed_out = (TIMEOUT != 0) && (count == TMAX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_IDLE;
            count     <= '0;
            o_wb_addr <= '0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 4'b0000;
            o_wb_we   <= 1'b0;
            o_wb_dat  <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            o_done  <= 1'b0;
            o_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_store != 2'd0) begin
                        if (misaligned) begin
                            o_error <= 1'b1;
                        end else begin
                            state     <= S_BUS;
                            count     <= '0;
                            o_wb_addr <= {i_addr[31:2], 2'b00};
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= lane_sel;
                            o_wb_we   <= 1'b1;
                            o_wb_dat  <= lane_dat;
                            o_busy    <= 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    if (i_wb_err || i_wb_ack || timed_out) begin
                        state    <= S_IDLE;
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 4'b0000;
                        o_wb_we  <= 1'b0;
                        o_busy   <= 1'b0;
                        o_done   <= !i_wb_err && i_wb_ack;
                        o_error  <= i_wb_err || !i_wb_ack;
                    end else if (TIMEOUT != 0) begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store.sv
// tb/tb_store.sv - scoreboard bench for store: random stores against a byte-lane model
module tb_store;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] o_wb_addr;
    logic        o_wb_cyc;
    logic [3:0]  o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic [1:0]  i_store;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    always #5 clk = ~clk;

    store #(.TIMEOUT(TO)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .o_wb_addr(o_wb_addr),
        .o_wb_cyc (o_wb_cyc),
        .o_wb_stb (o_wb_stb),
        .o_wb_we  (o_wb_we),
        .o_wb_dat (o_wb_dat),
        .i_wb_dat (i_wb_dat),
        .i_wb_ack (i_wb_ack),
        .i_wb_err (i_wb_err),
        .i_store  (i_store),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_error  (o_error)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  stb;
        logic [31:0] dat;
        int          len;
    } bus_t;

    bus_t bus_q[$];
    int   out_q[$];   // 1 = done, 2 = error
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_misaligned(input int sz, input logic [31:0] a);
        return (sz == 2 && a[0]) || (sz == 3 && a[1:0] != 2'b00);
    endfunction

    // Byte at address offset o lands on lane 3-o; the data word repeats across all lanes.
    function automatic bus_t model(input int sz, input logic [31:0] a, input logic [31:0] d, input int len);
        bus_t e;
        int bytes = 1 << (sz - 1);
        int off   = int'(a[1:0]);
        e.addr = {a[31:2], 2'b00};
        e.stb  = 4'b0000;
        e.dat  = '0;
        e.len  = len;
        for (int o = 0; o < bytes; o++) e.stb[3 - (off + o)] = 1'b1;
        for (int i = 0; i < 4; i++) e.dat[8*i +: 8] = d[8*(i % bytes) +: 8];
        return e;
    endfunction

    // kind: 0 ack, 1 err, 2 ack+err, 3 no response (timeout)
    task automatic xact(input int sz, input logic [31:0] a, input logic [31:0] d,
                        input int kind, input int w, input bit junk);
        int k;
        if (is_misaligned(sz, a)) begin
            out_q.push_back(2);
        end else begin
            bus_q.push_back(model(sz, a, d, (kind == 3) ? TO + 1 : w + 1));
            out_q.push_back((kind == 0) ? 1 : 2);
        end
        i_store = 2'(sz);
        i_addr  = a;
        i_data  = d;
        @(posedge clk); #1;
        i_store = 2'd0;
        if (is_misaligned(sz, a)) return;
        if (kind == 3) begin
            k = 0;
            while (o_wb_cyc && k < TO + 8) begin
                if (junk) begin
                    i_store = 2'($urandom_range(1, 3));
                    i_addr  = $urandom & 32'hFFFF_FFFC;
                end
                @(posedge clk); #1;
                i_store = 2'd0;
                k++;
            end
            if (o_wb_cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout_bound: cyc still high after %0d cycles, expected low", k);
            end
        end else begin
            repeat (w) begin
                if (junk) begin
                    i_store = 2'($urandom_range(1, 3));
                    i_addr  = $urandom & 32'hFFFF_FFFC;
                end
                @(posedge clk); #1;
                i_store = 2'd0;
            end
            i_wb_ack = (kind != 1);
            i_wb_err = (kind != 0);
            @(posedge clk); #1;
            i_wb_ack = 1'b0;
            i_wb_err = 1'b0;
        end
    endtask

    // Monitor: checks every bus cycle and every completion pulse against the queues.
    initial begin
        bit   prev = 1'b0;
        bit   have = 1'b0;
        int   len = 0;
        bus_t cur;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev = 1'b0;
                continue;
            end
            if (o_wb_cyc) begin
                if (!prev) begin
                    len = 0;
                    if (bus_q.size() == 0) begin
                        have = 1'b0;
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_cycle: cyc=1 addr 0x%08h, expected no cycle", o_wb_addr);
                    end else begin
                        have = 1'b1;
                        cur  = bus_q.pop_front();
                    end
                end
                len++;
                if (have) begin
                    chk("wb_addr", o_wb_addr, cur.addr);
                    chk("wb_stb", 32'(o_wb_stb), 32'(cur.stb));
                    chk("wb_dat", o_wb_dat, cur.dat);
                    chk("wb_we", 32'(o_wb_we), 32'd1);
                    chk("busy_in_bus", 32'(o_busy), 32'd1);
                end
            end else begin
                if (prev && have) chk("cyc_len", len, cur.len);
                chk("idle_stb_we", {27'd0, o_wb_stb, o_wb_we}, 32'd0);
            end
            if (o_done || o_error) begin
                chk("done_err_excl", 32'(o_done & o_error), 32'd0);
                chk("busy_at_end", 32'(o_busy), 32'd0);
                if (out_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: done=%0b error=%0b, expected none", o_done, o_error);
                end else begin
                    chk("outcome", {30'd0, o_error, o_done}, (out_q.pop_front() == 1) ? 32'd1 : 32'd2);
                end
            end
            prev = o_wb_cyc;
        end
    end

    initial begin
        int r;
        int kind;
        rst      = 1'b1;
        i_store  = 2'd0;
        i_addr   = '0;
        i_data   = '0;
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        i_wb_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rst_stb", 32'(o_wb_stb), 32'd0);
        chk("rst_we", 32'(o_wb_we), 32'd0);
        chk("rst_dat", o_wb_dat, 32'd0);
        chk("rst_addr", o_wb_addr, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done_err", {30'd0, o_done, o_error}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        xact(1, 32'h0000_1003, 32'h0000_00AB, 0, 2, 1'b0);
        xact(2, 32'h0000_2000, 32'h0000_1234, 0, 0, 1'b0);
        xact(2, 32'h0000_2002, 32'h0000_1234, 0, 0, 1'b0);
        xact(3, 32'h0000_3001, 32'hDEAD_BEEF, 0, 0, 1'b0);
        xact(2, 32'h0000_3001, 32'hDEAD_BEEF, 0, 0, 1'b0);
        xact(3, 32'h0000_4000, 32'hCAFE_F00D, 1, 0, 1'b0);
        xact(3, 32'h0000_4000, 32'hCAFE_F00D, 2, 1, 1'b0);
        xact(3, 32'h0000_5000, 32'h0102_0304, 3, 0, 1'b1);

        for (int n = 0; n < 200; n++) begin
            r    = $urandom_range(0, 9);
            kind = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
            xact($urandom_range(1, 3), $urandom, $urandom, kind,
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 3) == 0) i_wb_ack = 1'b1;
                if ($urandom_range(0, 3) == 0) i_wb_err = 1'b1;
                @(posedge clk); #1;
                i_wb_ack = 1'b0;
                i_wb_err = 1'b0;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        mon_en  = 1'b0;
        i_store = 2'd3;
        i_addr  = 32'h0000_6000;
        i_data  = 32'h5555_AAAA;
        @(posedge clk); #1;
        i_store = 2'd0;
        chk("rstmid_cyc_before", 32'(o_wb_cyc), 32'd1);
        i_wb_ack = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        i_wb_ack = 1'b0;
        rst      = 1'b0;
        chk("rstmid_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rstmid_stb", 32'(o_wb_stb), 32'd0);
        chk("rstmid_we", 32'(o_wb_we), 32'd0);
        chk("rstmid_dat_addr", o_wb_dat | o_wb_addr, 32'd0);
        chk("rstmid_busy", 32'(o_busy), 32'd0);
        chk("rstmid_pulse", {30'd0, o_done, o_error}, 32'd0);
        @(posedge clk); #1;
        chk("rstmid_pulse_after", {30'd0, o_done, o_error}, 32'd0);
        mon_en = 1'b1;
        xact(3, 32'h0000_7000, 32'h1122_3344, 0, 1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("out_q_drained", out_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store.md
# store

Wishbone bus-master store unit for the dcpu memory stage; the write-side counterpart of the load unit. It accepts an 8/16/32-bit store request, drives one Wishbone write cycle with big-endian byte-lane selects, and reports completion or error. Misaligned requests are rejected without a bus cycle, and a bus timeout aborts cycles that never terminate.

## Interface
Parameters:
- TIMEOUT, 255, max cycles a bus cycle may stay open without ack/err; 0 disables the timeout.

Ports:
- i_clk  in  1  clock; all state changes on posedge.
- i_reset  in  1  synchronous, active-high reset.
- o_wb_addr  out  32  word address `{addr[31:2], 2'b00}`, registered.
- o_wb_cyc  out  1  bus cycle active.
- o_wb_stb  out  4  per-byte-lane strobe/select; bit 3 = bits 31:24.
- o_wb_we  out  1  write enable; 1 whenever o_wb_cyc = 1, otherwise 0.
- o_wb_dat  out  32  write data, lane-replicated.
- i_wb_dat  in  32  unused.
- i_wb_ack  in  1  cycle terminated OK.
- i_wb_err  in  1  cycle terminated with error.
- i_store  in  2  request and size: 0 = none, 1 = 8-bit, 2 = 16-bit, 3 = 32-bit.
- i_addr  in  32  byte address, sampled with the request.
- i_data  in  32  store data, LSB-aligned, sampled with the request.
- o_busy  out  1  unit not in IDLE; requests are ignored while set.
- o_done  out  1  one-cycle pulse on successful completion.
- o_error  out  1  one-cycle pulse on misalignment, bus error or timeout.

## Operation
- States: IDLE and BUS.
- **IDLE**
  - cyc = 0, stb = 0, we = 0.
  - On i_store != 0, register addr, data and size.
  - If misaligned (size 2 with addr[0] = 1; size 3 with addr[1:0] != 0): stay in IDLE, pulse o_error next cycle, no bus activity.
  - Else go to BUS.
- **BUS**
  - cyc = 1, we = 1; stb and dat are held constant for the whole cycle.
  - 8-bit: stb = 1000 / 0100 / 0010 / 0001 for addr[1:0] = 0 / 1 / 2 / 3; dat = {4{d[7:0]}}.
  - 16-bit: stb = 1100 if addr[1] = 0, else 0011; dat = {2{d[15:0]}}.
  - 32-bit: stb = 1111; dat = d.
- **Termination**, evaluated on each BUS cycle:
  - i_wb_err: go to IDLE, o_error pulse.
  - Else i_wb_ack: go to IDLE, o_done pulse.
  - Else timeout counter == TIMEOUT (TIMEOUT != 0): go to IDLE, o_error pulse.
  - Priority: err > ack > timeout.
- **Timeout counter**
  - Cleared on entry to BUS; increments each BUS cycle without ack/err.
  - Width is clog2(TIMEOUT+1); it never wraps.
- ack/err seen while in IDLE are ignored.
- i_store seen while in BUS is ignored and not queued.

## Timing
- Reset values: o_wb_cyc = 0, o_wb_stb = 0, o_wb_we = 0, o_wb_dat = 0, o_wb_addr = 0, o_busy = 0, o_done = 0, o_error = 0, state = IDLE, counter = 0.
- Request sampled at edge N → cyc/stb/we/addr/dat valid after edge N (one-cycle issue latency).
- Ack sampled at edge M:
  - cyc/stb/we drop after edge M.
  - o_done is high for the cycle after edge M.
  - o_busy is low in the same cycle as o_done.
- A new request may be presented in the o_done/o_error cycle. Back-to-back throughput is 1 store per 2 cycles with zero-wait ack.
- Misaligned request at edge N → o_error high for the cycle after edge N; o_busy stays 0.
- Timeout: with no ack/err, o_error rises TIMEOUT+1 cycles after cyc rises, and cyc drops in the same cycle.
- Reset mid-cycle:
  - cyc/stb drop after the reset edge.
  - No done/error pulse is produced.
  - A pending ack in the same cycle as reset is discarded.
- o_done and o_error are never high together.

## Test plan
- **Byte store.** i_store = 1, addr = 0x1003, data = 0xAB, ack after 2 wait cycles → addr 0x1000, stb = 0001, dat = 0xABABABAB, we = 1 for 3 cycles, then a single o_done pulse.
- **Half store.** i_store = 2, addr = 0x2000, data = 0x1234; then addr = 0x2002 → stb = 1100 then 0011, dat = 0x12341234 both times; two o_done pulses, 2 cycles apart with zero-wait ack.
- **Misaligned.**
  - i_store = 3, addr = 0x3001 → no cyc ever, o_error pulse 1 cycle later.
  - i_store = 2, addr = 0x3001 → same result.
- **Bus error.**
  - i_store = 3, addr = 0x4000, err on the 1st BUS cycle → o_error pulse, no o_done, cyc low next cycle.
  - ack and err asserted together → o_error only.
- **Timeout.** TIMEOUT = 4, no ack → cyc high exactly 5 cycles, then o_error pulse. A request issued during BUS is ignored: no second cycle appears.
- **Reset mid-cycle.** Assert i_reset while cyc = 1, with ack in the same cycle → all outputs 0 next cycle, no done/error. The first request after reset completes normally.
